// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and helpers for the parametrised UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus falling-edge detect on the synchronised line.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rxs,
   output logic fall
);

   logic meta_reg;
   logic rxs_reg;
   logic prev_reg;

   // All stages reset high so that reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_reg <= 1'b1;
         rxs_reg  <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= rx;
         rxs_reg  <= meta_reg;
         prev_reg <= rxs_reg;
      end
   end

   assign rxs  = rxs_reg;
   assign fall = prev_reg & ~rxs_reg;

endmodule

// File: rtl/uart_rcv_param.sv
// Parametrised UART receiver with parity, stop-bit and overrun reporting.
// Build option UART_RCV_MAJORITY_EN selects 2-of-3 majority bit sampling.
module uart_rcv_param
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BAUD_DIV  = 2604,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   input  logic              rx_rdy_clr,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_rdy,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam int IDX_W = $clog2(DATA_W + 1);

   logic rxs;
   logic fall;
   logic bit_smp;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (RX),
      .rxs  (rxs),
      .fall (fall)
   );

`ifdef UART_RCV_MAJORITY_EN
   localparam int MAJ_DLY = 1;

   // hist_reg[0] holds rxs one cycle back, hist_reg[1] two cycles back.
   logic [1:0] hist_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_reg <= 2'b11;
      end else begin
         hist_reg <= {hist_reg[0], rxs};
      end
   end

   assign bit_smp = maj3(rxs, hist_reg[0], hist_reg[1]);
`else
   localparam int MAJ_DLY = 0;

   assign bit_smp = rxs;
`endif

   // With majority voting every decision lands one cycle after mid-bit; the
   // start decision absorbs that cycle so later bits keep a BAUD_DIV spacing.
   localparam logic [CNT_W-1:0] START_PT  = CNT_W'(BAUD_DIV / 2 + MAJ_DLY);
   localparam logic [CNT_W-1:0] BIT_PT    = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   rx_state_t         state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [DATA_W-1:0] shift_reg;
   logic              ferr_reg;
   logic              perr_reg;
   logic              par_exp;

   assign par_exp = (PARITY == PAR_ODD)  ? ~(^shift_reg) :
                    (PARITY == PAR_EVEN) ?   ^shift_reg   : 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         ferr_reg   <= 1'b0;
         perr_reg   <= 1'b0;
         rx_data    <= '0;
         rx_rdy     <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (rx_rdy_clr) begin
            rx_rdy  <= 1'b0;
            overrun <= 1'b0;
         end

         case (state_reg)
            S_IDLE: begin
               if (fall) begin
                  cnt_reg   <= '0;
                  state_reg <= S_START;
               end
            end

            S_START: begin
               if (cnt_reg == START_PT) begin
                  cnt_reg <= '0;
                  if (bit_smp) begin
                     state_reg <= S_IDLE;
                  end else begin
                     idx_reg   <= '0;
                     ferr_reg  <= 1'b0;
                     perr_reg  <= 1'b0;
                     state_reg <= S_DATA;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            S_DATA: begin
               if (cnt_reg == BIT_PT) begin
                  cnt_reg   <= '0;
                  shift_reg <= {bit_smp, shift_reg[DATA_W-1:1]};
                  if (idx_reg == LAST_DATA) begin
                     idx_reg   <= '0;
                     state_reg <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                  end else begin
                     idx_reg <= idx_reg + IDX_ONE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            S_PARITY: begin
               if (cnt_reg == BIT_PT) begin
                  cnt_reg   <= '0;
                  perr_reg  <= (bit_smp != par_exp);
                  idx_reg   <= '0;
                  state_reg <= S_STOP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            S_STOP: begin
               if (cnt_reg == BIT_PT) begin
                  cnt_reg <= '0;
                  if (!bit_smp) begin
                     ferr_reg <= 1'b1;
                  end
                  if (idx_reg == LAST_STOP) begin
                     // Commit overrides any simultaneous clear of rx_rdy/overrun.
                     rx_data    <= shift_reg;
                     frame_err  <= ferr_reg | ~bit_smp;
                     parity_err <= perr_reg;
                     rx_rdy     <= 1'b1;
                     overrun    <= rx_rdy_clr ? 1'b0 : (overrun | rx_rdy);
                     idx_reg    <= '0;
                     state_reg  <= S_IDLE;
                  end else begin
                     idx_reg <= idx_reg + IDX_ONE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rcv_param.md
# uart_rcv_param

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It adds configurable data width, bit period, parity, stop-bit count and an input synchroniser. It reports framing, parity and overrun errors alongside the received word. It sits between the board RX pin and the command/packet layer, with the same `rx_rdy`/`rx_rdy_clr` handshake as the existing receiver.

## Interface
- `DATA_W`, 8, data bits per frame; legal 5..9.
- `BAUD_DIV`, 2604, clk cycles per bit; legal >= 8; the counter width is `$clog2(BAUD_DIV)`.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits checked; legal 1 or 2.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `RX`  in  1  asynchronous serial line; idles high.
- `rx_rdy_clr`  in  1  one-cycle pulse; consumer has taken `rx_data`.
- `rx_data`  out  DATA_W  last received word, LSB first on the line.
- `rx_rdy`  out  1  word available; held until cleared.
- `frame_err`  out  1  a stop bit of the last word sampled low.
- `parity_err`  out  1  parity mismatch on the last word; always 0 when `PARITY`=0.
- `overrun`  out  1  sticky; a word completed while `rx_rdy` was still set.

## Operation
- `RX` passes through a 2-flop synchroniser (`rxs`). Start detection uses the falling edge of `rxs` (previous 1, current 0). A line held low (break) therefore yields at most one frame.
- States:
  - IDLE: on falling edge, clear the baud counter and go to START.
  - START: at count `BAUD_DIV/2`, sample the line. If high, it is a false start: return to IDLE with no flag changes. If low, clear the counter, clear the bit index, and go to DATA.
  - DATA: sample at count `BAUD_DIV-1` (mid-bit, because START is offset by half a bit). Shift the sample into the MSB of a DATA_W shift register and increment the index. After DATA_W bits, go to PARITY if `PARITY`!=0, else STOP.
  - PARITY: sample the bit and compare against the XOR of the data (even) or its inverse (odd).
  - STOP: sample STOP_BITS bits. Any low sample sets the internal frame error. After the last stop sample, commit and go to IDLE.
- Commit, on a single cycle:
  - `rx_data` ← shift register.
  - `frame_err` and `parity_err` ← the internal results for this frame.
  - `rx_rdy` ← 1.
  - `overrun` ← 1 if `rx_rdy` was already 1 and `rx_rdy_clr` is not asserted in that cycle.
- A new word always overwrites `rx_data`.
- `rx_rdy_clr` clears `rx_rdy` and `overrun`. If clear and commit coincide, the commit wins: `rx_rdy` stays 1 and `overrun` is not set.
- The receiver accepts a new start edge in the cycle after commit. There is no hunt for idle beyond the edge requirement.

## Timing
- Reset: state IDLE, counters 0. All outputs are 0: `rx_data`=0, `rx_rdy`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. The synchroniser flops reset to 1.
- Reset asserted mid-frame discards the frame on the next edge. No flag is set.
- Latency: `rx_rdy` rises at the edge that samples the last stop bit, plus 2 cycles of synchroniser delay. Measured from the falling `RX` edge this is ((1+DATA_W+P+STOP_BITS)−0.5)·BAUD_DIV + 2 cycles, ±1, where P=1 if parity is enabled.
- Error flags are valid whenever `rx_rdy`=1 and remain stable until the next commit.

## Configuration
- `UART_RCV_MAJORITY_EN`:
  - Defined: every bit sample (start, data, parity and stop) is the 2-of-3 majority of `rxs` at counts mid−1, mid and mid+1. The decision is made at mid+1, which adds 1 cycle to latency.
  - Undefined: single sample at mid.
- Parameter legality is identical in both builds.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Parity-mode localparams `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
- Sub-module `uart_rx_sync`: 2-flop synchroniser plus falling-edge detect. Outputs `rxs` and `fall`.
- Baud counter, index counter, FSM and output registers stay in the top module.

## Test plan
Bench uses `BAUD_DIV`=16, `DATA_W`=8 unless noted.
- 8N1 frame 0xA5, then `rx_rdy_clr` → `rx_rdy`=1 with `rx_data`=0xA5 and all flags 0; one cycle after the clear, `rx_rdy`=0.
- `PARITY`=1 (even): send 0x07 with parity bit 1 → `parity_err`=0. Send 0x07 with parity bit 0 → `parity_err`=1, `rx_data`=0x07.
- Stop bit driven low on 0x3C → `frame_err`=1, `rx_data`=0x3C. Next frame is 0x11 with good stop; the line must return high first → `frame_err`=0.
- Two frames 0x01, 0x02 with no clear → `rx_data`=0x02 and `overrun`=1. Clear in the same cycle as the second commit → `overrun`=0 and `rx_rdy`=1.
- 4-cycle low glitch on idle `RX` → no `rx_rdy`, state back in IDLE. `rst_n` low at data bit 3 → all outputs 0, then the next full frame 0x5A is received correctly.
- With `UART_RCV_MAJORITY_EN`: 1-cycle inverted glitch at mid of bit 2 of 0xFF → `rx_data`=0xFF. Without the macro → `rx_data`=0xFB.
